// File: rtl/opp8_port_sched_if.sv
`default_nettype none
// ============================================================================
// Module   : opp8_port_sched_if
// Purpose  : Request/release and port-enable bundle of the OPP8 port scheduler.
// Revision : 1.0 - initial release
// ============================================================================
interface opp8_port_sched_if;
    logic [7:0] req;
    logic [7:0] done;
    logic       bcast_req;
    logic       bcast_done;
    logic [7:0] port_en;
    logic       grant_valid;
    logic [2:0] grant_id;
    logic       timeout;

    // master: control-unit side; slave: the scheduler
    modport master (
        output req, done, bcast_req, bcast_done,
        input  port_en, grant_valid, grant_id, timeout
    );
    modport slave (
        input  req, done, bcast_req, bcast_done,
        output port_en, grant_valid, grant_id, timeout
    );
endinterface
`default_nettype wire

// File: rtl/opp8_port_sched.sv
`default_nettype none
// ============================================================================
// Module   : opp8_port_sched
// Purpose  : Round-robin / broadcast scheduler for the 8-port OPP8 enable bank
//            with break-before-make gap and per-grant hold timeout.
// Revision : 1.0 - initial release
// ============================================================================
module opp8_port_sched #(
    parameter int MAX_HOLD      = 16,
    parameter bit BCAST_TIMEOUT = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst,
    opp8_port_sched_if.slave       bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_BCAST = 2'd2,
        ST_GAP   = 2'd3
    } state_t;

    localparam logic [15:0] c_hold_last = (MAX_HOLD == 0) ? 16'd0 : 16'(MAX_HOLD - 1);

    state_t      r_state;
    logic [2:0]  r_ptr;
    logic [15:0] r_cnt;
    logic [7:0]  r_port_en;
    logic        r_grant_valid;
    logic [2:0]  r_grant_id;
    logic        r_timeout;

    state_t      w_state_nxt;
    logic [2:0]  w_ptr_nxt;
    logic [15:0] w_cnt_nxt;
    logic [7:0]  w_port_en_nxt;
    logic        w_valid_nxt;
    logic [2:0]  w_id_nxt;
    logic        w_timeout_nxt;

    logic [2:0]  w_winner;
    logic        w_found;
    logic        w_hold_hit;
    logic        w_user_rel;
    logic        w_tmo_rel;

    // First requesting port at or after the rotating pointer
    always_comb begin
        w_winner = 3'd0;
        w_found  = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (!w_found && bus.req[r_ptr + 3'(i)]) begin
                w_winner = r_ptr + 3'(i);
                w_found  = 1'b1;
            end
        end
    end

    assign w_hold_hit = (MAX_HOLD != 0) && (r_cnt == c_hold_last);

    always_comb begin
        w_state_nxt   = r_state;
        w_ptr_nxt     = r_ptr;
        w_cnt_nxt     = r_cnt;
        w_port_en_nxt = r_port_en;
        w_valid_nxt   = r_grant_valid;
        w_id_nxt      = r_grant_id;
        w_timeout_nxt = 1'b0;
        w_user_rel    = 1'b0;
        w_tmo_rel     = 1'b0;

        case (r_state)
            ST_IDLE, ST_GAP: begin
                w_cnt_nxt = 16'd0;
                if (bus.bcast_req) begin
                    w_state_nxt   = ST_BCAST;
                    w_port_en_nxt = 8'hFF;
                    w_valid_nxt   = 1'b1;
                    w_id_nxt      = 3'd0;
                end else if (w_found) begin
                    w_state_nxt   = ST_GRANT;
                    w_port_en_nxt = 8'h01 << w_winner;
                    w_valid_nxt   = 1'b1;
                    w_id_nxt      = w_winner;
                end else begin
                    w_state_nxt   = ST_IDLE;
                    w_port_en_nxt = 8'h00;
                    w_valid_nxt   = 1'b0;
                    w_id_nxt      = 3'd0;
                end
            end
            ST_GRANT, ST_BCAST: begin
                if (r_state == ST_GRANT) begin
                    w_user_rel = bus.done[r_grant_id] | ~bus.req[r_grant_id];
                    w_tmo_rel  = w_hold_hit;
                end else begin
                    w_user_rel = bus.bcast_done | ~bus.bcast_req;
                    w_tmo_rel  = BCAST_TIMEOUT & w_hold_hit;
                end
                if (w_user_rel || w_tmo_rel) begin
                    // Broadcast exit leaves the rotation pointer untouched
                    if (r_state == ST_GRANT) begin
                        w_ptr_nxt = r_grant_id + 3'd1;
                    end
                    w_state_nxt   = ST_GAP;
                    w_cnt_nxt     = 16'd0;
                    w_port_en_nxt = 8'h00;
                    w_valid_nxt   = 1'b0;
                    w_id_nxt      = 3'd0;
                    w_timeout_nxt = ~w_user_rel;
                end else begin
                    w_cnt_nxt = (r_cnt == 16'hFFFF) ? r_cnt : r_cnt + 16'd1;
                end
            end
            default: begin
                w_state_nxt   = ST_IDLE;
                w_cnt_nxt     = 16'd0;
                w_port_en_nxt = 8'h00;
                w_valid_nxt   = 1'b0;
                w_id_nxt      = 3'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= ST_IDLE;
            r_ptr         <= 3'd0;
            r_cnt         <= 16'd0;
            r_port_en     <= 8'h00;
            r_grant_valid <= 1'b0;
            r_grant_id    <= 3'd0;
            r_timeout     <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_ptr         <= w_ptr_nxt;
            r_cnt         <= w_cnt_nxt;
            r_port_en     <= w_port_en_nxt;
            r_grant_valid <= w_valid_nxt;
            r_grant_id    <= w_id_nxt;
            r_timeout     <= w_timeout_nxt;
        end
    end

    assign bus.port_en     = r_port_en;
    assign bus.grant_valid = r_grant_valid;
    assign bus.grant_id    = r_grant_id;
    assign bus.timeout     = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_opp8_port_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_opp8_port_sched
// Purpose  : Self-checking bench for opp8_port_sched (two parameterisations).
// Revision : 1.0 - initial release
// ============================================================================
module tb_opp8_port_sched;

    localparam int MH_A = 4;
    localparam bit BT_A = 1'b1;
    localparam int MH_B = 2;
    localparam bit BT_B = 1'b0;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] req;
    logic [7:0] done;
    logic       bcast_req;
    logic       bcast_done;

    int checks = 0;
    int errors = 0;

    opp8_port_sched_if ifa ();
    opp8_port_sched_if ifb ();

    assign ifa.req = req;        assign ifb.req = req;
    assign ifa.done = done;      assign ifb.done = done;
    assign ifa.bcast_req = bcast_req;   assign ifb.bcast_req = bcast_req;
    assign ifa.bcast_done = bcast_done; assign ifb.bcast_done = bcast_done;

    opp8_port_sched #(.MAX_HOLD(MH_A), .BCAST_TIMEOUT(BT_A)) u_dut_a (
        .clk (clk),
        .rst (rst),
        .bus (ifa)
    );

    opp8_port_sched #(.MAX_HOLD(MH_B), .BCAST_TIMEOUT(BT_B)) u_dut_b (
        .clk (clk),
        .rst (rst),
        .bus (ifb)
    );

    always #5 clk = ~clk;

    // Model: who holds the output path (-1 none, 0..7 port, 8 broadcast) and for how long
    typedef struct {
        int holder;
        int age;
        int ptr;
        bit to;
    } mstate_t;

    mstate_t ms_a;
    mstate_t ms_b;

    function automatic mstate_t step(input mstate_t s, input int mh, input bit bt,
                                     input logic [7:0] r, input logic [7:0] d,
                                     input logic br, input logic bd);
        mstate_t n;
        bit user;
        bit tmo;
        bit found;
        int c;
        n    = s;
        n.to = 1'b0;
        if (s.holder < 0) begin
            if (br) begin
                n.holder = 8;
                n.age    = 1;
            end else begin
                found = 1'b0;
                for (int i = 0; i < 8; i++) begin
                    c = (s.ptr + i) % 8;
                    if (!found && r[c]) begin
                        n.holder = c;
                        n.age    = 1;
                        found    = 1'b1;
                    end
                end
            end
        end else begin
            if (s.holder == 8) user = bd || !br;
            else               user = d[s.holder] || !r[s.holder];
            tmo = (mh != 0) && (s.age == mh) && (s.holder != 8 || bt);
            if (user || tmo) begin
                if (s.holder != 8) n.ptr = (s.holder + 1) % 8;
                n.holder = -1;
                n.age    = 0;
                n.to     = tmo && !user;
            end else begin
                n.age = s.age + 1;
            end
        end
        return n;
    endfunction

    function automatic logic [12:0] exp_out(input mstate_t s);
        logic [7:0] en;
        logic [2:0] id;
        en = (s.holder == 8) ? 8'hFF : (s.holder >= 0) ? (8'h01 << s.holder) : 8'h00;
        id = (s.holder >= 0 && s.holder < 8) ? 3'(s.holder) : 3'd0;
        return {en, (s.holder >= 0), id, s.to};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            ms_a <= '{-1, 0, 0, 1'b0};
            ms_b <= '{-1, 0, 0, 1'b0};
        end else begin
            ms_a <= step(ms_a, MH_A, BT_A, req, done, bcast_req, bcast_done);
            ms_b <= step(ms_b, MH_B, BT_B, req, done, bcast_req, bcast_done);
        end
    end

    // Cycle-by-cycle comparison of both instances against the model
    always @(negedge clk) begin
        if (rst) begin
            chk("model_a", {19'd0, ifa.port_en, ifa.grant_valid, ifa.grant_id, ifa.timeout},
                {19'd0, exp_out(ms_a)});
            chk("model_b", {19'd0, ifb.port_en, ifb.grant_valid, ifb.grant_id, ifb.timeout},
                {19'd0, exp_out(ms_b)});
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [2:0] ord [4];
        ord = '{3'd0, 3'd4, 3'd7, 3'd0};
        rst = 1'b0; req = 8'h00; done = 8'h00; bcast_req = 1'b0; bcast_done = 1'b0;

        // Reset state and first grant latency
        #2;
        chk("rst_en", 32'(ifa.port_en), 32'h00);
        chk("rst_valid", 32'(ifa.grant_valid), 32'h0);
        chk("rst_id", 32'(ifa.grant_id), 32'h0);
        chk("rst_to", 32'(ifa.timeout), 32'h0);
        @(negedge clk);
        rst = 1'b1; req = 8'h04;
        tick(1);
        chk("first_en", 32'(ifa.port_en), 32'h04);
        chk("first_id", 32'(ifa.grant_id), 32'h2);
        chk("first_valid", 32'(ifa.grant_valid), 32'h1);

        // Asynchronous reset mid-grant
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        chk("async_en_a", 32'(ifa.port_en), 32'h00);
        chk("async_en_b", 32'(ifb.port_en), 32'h00);
        chk("async_valid", 32'(ifa.grant_valid), 32'h0);
        @(negedge clk);
        rst = 1'b1; req = 8'h00;
        tick(2);

        // Round-robin 0,4,7,0 with one gap cycle between grants
        req = 8'h91;
        tick(1);
        for (int i = 0; i < 4; i++) begin
            chk("rr_id", 32'(ifa.grant_id), 32'(ord[i]));
            chk("rr_en", 32'(ifa.port_en), 32'(8'h01 << ord[i]));
            tick(1);
            done = 8'h01 << ord[i];
            tick(1);
            done = 8'h00;
            chk("rr_gap", 32'(ifa.port_en), 32'h00);
            tick(1);
        end
        req = 8'h00;
        tick(3);

        // Hold timeout, then done coinciding with the timeout cycle
        req = 8'h02;
        for (int i = 0; i < 4; i++) begin
            tick(1);
            chk("to_hold", 32'(ifa.port_en), 32'h02);
        end
        tick(1);
        chk("to_gap_en", 32'(ifa.port_en), 32'h00);
        chk("to_pulse", 32'(ifa.timeout), 32'h1);
        tick(1);
        chk("to_regrant", 32'(ifa.port_en), 32'h02);
        chk("to_clear", 32'(ifa.timeout), 32'h0);
        tick(3);
        done = 8'h02;
        tick(1);
        done = 8'h00; req = 8'h00;
        chk("to_done_en", 32'(ifa.port_en), 32'h00);
        chk("to_done_pulse", 32'(ifa.timeout), 32'h0);
        tick(2);

        // Broadcast waits for the current grant, then ptr resumes at 4
        req = 8'h18;
        tick(1);
        chk("bc_id3", 32'(ifa.grant_id), 32'h3);
        bcast_req = 1'b1;
        tick(1);
        chk("bc_keep3", 32'(ifa.port_en), 32'h08);
        done = 8'h08;
        tick(1);
        done = 8'h00;
        chk("bc_gap1", 32'(ifa.port_en), 32'h00);
        tick(1);
        chk("bc_en", 32'(ifa.port_en), 32'hFF);
        chk("bc_id", 32'(ifa.grant_id), 32'h0);
        bcast_done = 1'b1;
        tick(1);
        bcast_done = 1'b0; bcast_req = 1'b0;
        chk("bc_gap2", 32'(ifa.port_en), 32'h00);
        chk("bc_noto", 32'(ifa.timeout), 32'h0);
        tick(1);
        chk("bc_next_id", 32'(ifa.grant_id), 32'h4);
        req = 8'h00;
        tick(3);

        // Foreign done bits ignored; drop of own req releases, ptr moves to 6
        req = 8'h20;
        tick(1);
        chk("ig_id5", 32'(ifa.grant_id), 32'h5);
        done = 8'hDF;
        tick(1);
        done = 8'h00;
        chk("ig_hold", 32'(ifa.port_en), 32'h20);
        req = 8'h00;
        tick(1);
        chk("ig_gap", 32'(ifa.port_en), 32'h00);
        req = 8'h41;
        tick(1);
        chk("ig_ptr6", 32'(ifa.grant_id), 32'h6);
        req = 8'h00;
        tick(4);

        // Simultaneous arrival, broadcast exempt from timeout on instance B
        bcast_req = 1'b1; req = 8'hFF;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            chk("sim_en_b", 32'(ifb.port_en), 32'hFF);
            chk("sim_to_b", 32'(ifb.timeout), 32'h0);
        end
        bcast_done = 1'b1;
        tick(1);
        bcast_done = 1'b0; bcast_req = 1'b0; req = 8'h00;
        chk("sim_rel_b", 32'(ifb.port_en), 32'h00);
        chk("sim_rel_to_b", 32'(ifb.timeout), 32'h0);
        tick(4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
